// File: rtl/inst_decode_queue_if.sv
// Handshake bundle between IF, the IF/ID instruction queue and the ID decoder.
// The queue takes the slave modport; the fetch/decode side takes master.
interface inst_decode_queue_if #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned GHR_WIDTH  = 5
);
  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                          flush;
  logic [WIDTH-1:0]              push_valid;
  logic [WIDTH*ADDR_WIDTH-1:0]   push_pc;
  logic [WIDTH*INST_WIDTH-1:0]   push_inst;
  logic [WIDTH-1:0]              push_taken;
  logic [WIDTH*GHR_WIDTH-1:0]    push_pht_index;
  logic                          push_ready;
  logic [WIDTH-1:0]              out_valid;
  logic [WIDTH*ADDR_WIDTH-1:0]   out_pc;
  logic [WIDTH*INST_WIDTH-1:0]   out_inst;
  logic [WIDTH-1:0]              out_taken;
  logic [WIDTH*GHR_WIDTH-1:0]    out_pht_index;
  logic [PopW-1:0]               pop_count;
  logic [CntW-1:0]               count;

  modport master (
    output flush, push_valid, push_pc, push_inst, push_taken, push_pht_index, pop_count,
    input  push_ready, out_valid, out_pc, out_inst, out_taken, out_pht_index, count
  );

  modport slave (
    input  flush, push_valid, push_pc, push_inst, push_taken, push_pht_index, pop_count,
    output push_ready, out_valid, out_pc, out_inst, out_taken, out_pht_index, count
  );
endinterface

// File: rtl/inst_decode_queue.sv
// IF/ID instruction queue: WIDTH-lane push, WIDTH-lane prefix pop, circular buffer of
// DEPTH entries with synchronous reset and full flush. DEPTH must be a power of two >= 2.
module inst_decode_queue #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned GHR_WIDTH  = 5
) (
  input logic               clk,
  input logic               rst,
  inst_decode_queue_if.slave q
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PopW = $clog2(WIDTH + 1);

  // Storage is deliberately not reset; validity comes from count_q alone.
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [INST_WIDTH-1:0] inst_q  [DEPTH];
  logic                  taken_q [DEPTH];
  logic [GHR_WIDTH-1:0]  pht_q   [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [PopW-1:0] n_push;
  logic            push_ready;
  logic            do_push;

  logic [WIDTH-1:0]            out_valid;
  logic [WIDTH*ADDR_WIDTH-1:0] out_pc;
  logic [WIDTH*INST_WIDTH-1:0] out_inst;
  logic [WIDTH-1:0]            out_taken;
  logic [WIDTH*GHR_WIDTH-1:0]  out_pht_index;

  always_comb begin
    n_push = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_push = n_push + PopW'(q.push_valid[i]);
    end
  end

  // Registered count only: a same-cycle pop never frees room for a push.
  assign push_ready = (CntW'(DEPTH) - count_q) >= CntW'(WIDTH);
  assign do_push    = push_ready & ~q.flush & ~rst;

  always_comb begin
    head_d  = head_q + PtrW'(q.pop_count);
    tail_d  = do_push ? tail_q + PtrW'(n_push) : tail_q;
    count_d = count_q + (do_push ? CntW'(n_push) : CntW'(0)) - CntW'(q.pop_count);
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (PopW'(i) < n_push) begin
          pc_q[tail_q + PtrW'(i)]    <= q.push_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
          inst_q[tail_q + PtrW'(i)]  <= q.push_inst[i*INST_WIDTH +: INST_WIDTH];
          taken_q[tail_q + PtrW'(i)] <= q.push_taken[i];
          pht_q[tail_q + PtrW'(i)]   <= q.push_pht_index[i*GHR_WIDTH +: GHR_WIDTH];
        end
      end
    end
  end

  // Invalid lanes drive zero so downstream never sees stale storage.
  always_comb begin
    out_valid     = '0;
    out_pc        = '0;
    out_inst      = '0;
    out_taken     = '0;
    out_pht_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = count_q > CntW'(i);
      if (out_valid[i]) begin
        out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]       = pc_q[head_q + PtrW'(i)];
        out_inst[i*INST_WIDTH +: INST_WIDTH]     = inst_q[head_q + PtrW'(i)];
        out_taken[i]                             = taken_q[head_q + PtrW'(i)];
        out_pht_index[i*GHR_WIDTH +: GHR_WIDTH]  = pht_q[head_q + PtrW'(i)];
      end
    end
  end

  assign q.push_ready    = push_ready;
  assign q.count         = count_q;
  assign q.out_valid     = out_valid;
  assign q.out_pc        = out_pc;
  assign q.out_inst      = out_inst;
  assign q.out_taken     = out_taken;
  assign q.out_pht_index = out_pht_index;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue (WIDTH=2, DEPTH=8) with hand-computed expectations.
module tb_inst_decode_queue;
  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned GW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_decode_queue_if #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INST_WIDTH(IW), .GHR_WIDTH(GW)
  ) dq_if ();

  inst_decode_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INST_WIDTH(IW), .GHR_WIDTH(GW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .q   (dq_if)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lane data is derived from the pc so every field can be predicted from it.
  task automatic drive(input logic [1:0] valid, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] pop);
    dq_if.push_valid     = valid;
    dq_if.push_pc        = {pc1, pc0};
    dq_if.push_inst      = {~pc1, ~pc0};
    dq_if.push_taken     = {pc1[2], pc0[2]};
    dq_if.push_pht_index = {pc1[6:2], pc0[6:2]};
    dq_if.pop_count      = pop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (!rst && !dq_if.flush) begin
      assert (dq_if.pop_count <= dq_if.count)
        else $error("pop_count %0d exceeds occupancy %0d", dq_if.pop_count, dq_if.count);
    end
  end

  initial begin
    rst         = 1'b1;
    dq_if.flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    check("rst_count", dq_if.count, 4'd0);
    check("rst_valid", dq_if.out_valid, 2'b00);
    check("rst_ready", dq_if.push_ready, 1'b1);
    check("rst_pc_zero", dq_if.out_pc, 64'h0);

    // First dual push, visible one cycle later
    drive(2'b11, 32'h0040_0000, 32'h0040_0004, 2'd0);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    check("p1_valid", dq_if.out_valid, 2'b11);
    check("p1_pc0", dq_if.out_pc[31:0], 32'h0040_0000);
    check("p1_pc1", dq_if.out_pc[63:32], 32'h0040_0004);
    check("p1_inst0", dq_if.out_inst[31:0], 32'hFFBF_FFFF);
    check("p1_taken", dq_if.out_taken, 2'b10);
    check("p1_pht", dq_if.out_pht_index, 10'h020);
    check("p1_count", dq_if.count, 4'd2);

    // Fill to DEPTH
    for (int k = 1; k < 4; k++) begin
      drive(2'b11, 32'h0040_0000 + 32'(8 * k), 32'h0040_0004 + 32'(8 * k), 2'd0);
      step();
    end
    check("full_count", dq_if.count, 4'd8);
    check("full_ready", dq_if.push_ready, 1'b0);

    // Push into full queue is ignored
    drive(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'd0);
    step();
    check("ovf_count", dq_if.count, 4'd8);
    check("ovf_head", dq_if.out_pc[31:0], 32'h0040_0000);

    // Pop 2 from full with a simultaneous push: push dropped
    drive(2'b11, 32'hBEEF_0000, 32'hBEEF_0004, 2'd2);
    step();
    check("fp_count", dq_if.count, 4'd6);
    check("fp_ready", dq_if.push_ready, 1'b1);
    check("fp_head", dq_if.out_pc[31:0], 32'h0040_0008);

    // Drain
    drive(2'b00, 32'h0, 32'h0, 2'd2);
    step();
    check("dr1_head", dq_if.out_pc[31:0], 32'h0040_0010);
    check("dr1_count", dq_if.count, 4'd4);
    step();
    check("dr2_pc0", dq_if.out_pc[31:0], 32'h0040_0018);
    check("dr2_pc1", dq_if.out_pc[63:32], 32'h0040_001C);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    check("dr3_count", dq_if.count, 4'd0);
    check("dr3_valid", dq_if.out_valid, 2'b00);

    // Single-lane stream across pointer wrap; lane 1 carries junk that must not land
    for (int k = 0; k < 20; k++) begin
      drive(2'b01, 32'h0000_1000 + 32'(4 * k), 32'hBAD0_0000, (k == 0) ? 2'd0 : 2'd1);
      step();
      check("str_pc", dq_if.out_pc[31:0], 32'h0000_1000 + 32'(4 * k));
      check("str_count", dq_if.count, 4'd1);
    end
    check("str_lane1_zero", dq_if.out_pc[63:32], 32'h0);
    drive(2'b00, 32'h0, 32'h0, 2'd1);
    step();
    check("str_empty", dq_if.count, 4'd0);

    // Build count=5, then flush with push and pop in the same cycle
    drive(2'b11, 32'h2000, 32'h2004, 2'd0);
    step();
    drive(2'b11, 32'h2008, 32'h200C, 2'd0);
    step();
    drive(2'b01, 32'h2010, 32'h0, 2'd0);
    step();
    check("pre_flush_count", dq_if.count, 4'd5);
    drive(2'b11, 32'h3000, 32'h3004, 2'd1);
    dq_if.flush = 1'b1;
    step();
    dq_if.flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    check("fl_count", dq_if.count, 4'd0);
    check("fl_valid", dq_if.out_valid, 2'b00);
    check("fl_ready", dq_if.push_ready, 1'b1);
    drive(2'b01, 32'h7000, 32'h0, 2'd0);
    step();
    check("afl_valid", dq_if.out_valid, 2'b01);
    check("afl_pc0", dq_if.out_pc[31:0], 32'h7000);
    check("afl_count", dq_if.count, 4'd1);

    // Concurrent push and pop, not full
    drive(2'b11, 32'h8000, 32'h8004, 2'd1);
    step();
    check("pp_count", dq_if.count, 4'd2);
    check("pp_pc0", dq_if.out_pc[31:0], 32'h8000);
    check("pp_pc1", dq_if.out_pc[63:32], 32'h8004);

    // count=7 leaves one slot: not enough for WIDTH lanes
    drive(2'b11, 32'h8008, 32'h800C, 2'd0);
    step();
    drive(2'b11, 32'h8010, 32'h8014, 2'd0);
    step();
    drive(2'b01, 32'h8018, 32'h0, 2'd0);
    step();
    check("c7_count", dq_if.count, 4'd7);
    check("c7_ready", dq_if.push_ready, 1'b0);
    drive(2'b01, 32'h9000, 32'h0, 2'd0);
    step();
    check("c7_hold", dq_if.count, 4'd7);
    drive(2'b11, 32'h9000, 32'h9004, 2'd1);
    step();
    check("c7_pop_count", dq_if.count, 4'd6);
    check("c7_pop_head", dq_if.out_pc[31:0], 32'h8004);

    // Reset mid-operation with push and pop pending
    drive(2'b11, 32'hA100, 32'hA104, 2'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    check("mr_count", dq_if.count, 4'd0);
    check("mr_valid", dq_if.out_valid, 2'b00);
    check("mr_ready", dq_if.push_ready, 1'b1);
    drive(2'b11, 32'hA000, 32'hA004, 2'd0);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'd0);
    check("amr_pc0", dq_if.out_pc[31:0], 32'hA000);
    check("amr_taken", dq_if.out_taken, 2'b10);
    check("amr_count", dq_if.count, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_decode_queue.md
Name: inst_decode_queue

Overview:
- Parametrised instruction buffer between the IF and ID stages of the out-of-order core.
- Accepts up to WIDTH fetched instructions per cycle, each carrying its pc, instruction word and branch-prediction info (taken flag, PHT index).
- Presents up to WIDTH oldest entries per cycle to a WIDTH-wide decoder, which consumes any prefix of them.
- Decouples fetch from decode stalls and supports a full flush on misprediction or exception.

Parameters:
WIDTH, 2, lanes per cycle on both push and pop sides; must satisfy 1 <= WIDTH <= DEPTH
DEPTH, 8, number of entries; must be a power of two
ADDR_WIDTH, 32, pc width
INST_WIDTH, 32, instruction word width
GHR_WIDTH, 5, PHT index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all entries; same-cycle push is dropped
push_valid  input  WIDTH  lane-valid mask from IF; must be a prefix mask (lane i valid implies lanes 0..i-1 valid)
push_pc  input  WIDTH*ADDR_WIDTH  lane i pc at [i*ADDR_WIDTH +: ADDR_WIDTH]
push_inst  input  WIDTH*INST_WIDTH  lane i instruction word
push_taken  input  WIDTH  lane i predicted-taken flag
push_pht_index  input  WIDTH*GHR_WIDTH  lane i PHT index
push_ready  output  1  queue accepts a push this cycle
out_valid  output  WIDTH  bit i set iff occupancy > i
out_pc  output  WIDTH*ADDR_WIDTH  pc of (i)-th oldest entry
out_inst  output  WIDTH*INST_WIDTH  instruction word of (i)-th oldest entry
out_taken  output  WIDTH  predicted-taken flag of (i)-th oldest entry
out_pht_index  output  WIDTH*GHR_WIDTH  PHT index of (i)-th oldest entry
pop_count  input  clog2(WIDTH+1)  entries consumed by ID this cycle; must be <= popcount(out_valid)
count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- State: storage array [DEPTH], head and tail pointers of clog2(DEPTH) bits, occupancy counter. Pointers wrap modulo DEPTH by natural overflow.
- Reset (rst=1 at posedge): head=tail=0, count=0. Consequently out_valid=0 and push_ready=1 from the next cycle. Storage contents are not reset. Outputs are X-free only where out_valid is set; invalid lanes output 0.
- push_ready = (DEPTH - count) >= WIDTH, computed from the registered count only. A same-cycle pop does not raise push_ready (no bypass).
- Push: when push_ready && !flush && !rst, n = popcount(push_valid) lanes are written at tail+0..tail+n-1 and tail advances by n. Lanes above n are ignored.
- If push_valid != 0 while push_ready=0, nothing is written. IF must hold its lanes.
- Pop: when !flush && !rst, head advances by pop_count. A pop_count larger than current occupancy is a protocol violation; the bench asserts it never occurs.
- Simultaneous push and pop: count_next = count + n_push - pop_count. Both pointers update in the same cycle.
- Output read: lane i shows array[(head+i) mod DEPTH] combinationally from registered state.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. one cycle push-to-decode. There is no fall-through in the push cycle.
- Flush: at the edge with flush=1, head=tail=0 and count=0; push and pop in that cycle are discarded. rst has priority over flush; the two have identical effect.
- Ordering: FIFO order is preserved across lanes and across wrap-around.
- Full: count=DEPTH gives push_ready=0. Empty: count=0 gives out_valid=0, and pop_count must be 0.
- Reset mid-operation discards all entries exactly as flush does.

Test Plan:
- Reset then idle -> count=0, out_valid=2'b00, push_ready=1 (WIDTH=2, DEPTH=8).
- Push 2'b11 with pc 0x00400000 and 0x00400004, pop_count=0 -> next cycle out_valid=2'b11, out_pc lane0=0x00400000, lane1=0x00400004, count=2.
- Four pushes of 2'b11 with no pop -> count=8, push_ready=0. A fifth push with push_valid=2'b11 is ignored: count stays 8 and the head entry is unchanged.
- Full queue with pop_count=2 and push_valid=2'b11 in the same cycle -> push dropped (push_ready=0), count=6. Next cycle push_ready=1.
- Steady stream of push 2'b01 and pop_count=1 for 20 cycles, pc incrementing by 4 -> out_pc lane0 tracks pushes with 1-cycle lag across pointer wrap; count stays at 1.
- count=5 with flush=1 together with push 2'b11 and pop_count=1 -> next cycle count=0 and out_valid=0. A push the following cycle appears in lane0.
